// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_scan_controller_pkg;

    localparam int unsigned NUM_DIGITS_DEFAULT = 6;
    localparam int unsigned AN_WIDTH_DEFAULT   = 8;
    localparam int unsigned DIGIT_W            = 4;

    // Wide enough for any sensible anode count; users slice to their width.
    localparam logic [31:0] AN_OFF = '1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StGap  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/display_scan_controller_if.sv
// Digit/anode bundle between the scan controller and its host logic.
interface display_scan_controller_if
    import display_scan_controller_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEFAULT,
    parameter int unsigned AN_WIDTH   = AN_WIDTH_DEFAULT
) ();

    logic                            enable;
    logic [DIGIT_W*NUM_DIGITS-1:0]   digit_bus;
    logic                            update;
    logic                            lz_blank;
    logic [DIGIT_W*NUM_DIGITS-1:0]   digit_q;
    logic [2:0]                      sel;
    logic [AN_WIDTH-1:0]             an;
    logic                            update_ack;
    logic                            frame_start;

    // Host side: supplies digits and controls, observes scan outputs.
    modport master (
        output enable, digit_bus, update, lz_blank,
        input  digit_q, sel, an, update_ack, frame_start
    );

    // Controller side.
    modport slave (
        input  enable, digit_bus, update, lz_blank,
        output digit_q, sel, an, update_ack, frame_start
    );

endinterface

// File: rtl/display_scan_controller_scan_slot_timer.sv
// Down-counter timing one ON or GAP interval; tc_o is high while the count is zero.
module display_scan_controller_scan_slot_timer #(
    parameter int unsigned CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear wins over load; otherwise count down and stick at zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed seven-segment scan sequencer with frame-coherent digit shadow,
// inter-digit dead time and optional leading-zero blanking.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = NUM_DIGITS_DEFAULT,
    parameter int unsigned AN_WIDTH    = AN_WIDTH_DEFAULT,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEADTIME    = 1000
) (
    input logic                      clk,
    input logic                      reset,
    display_scan_controller_if.slave scan_io
);

    localparam int unsigned DW    = DIGIT_W * NUM_DIGITS;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    // Timer loads length-1 so a slot of N cycles ends on the cycle the count hits zero.
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(REFRESH_DIV - DEADTIME - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((DEADTIME > 0) ? (DEADTIME - 1) : 0);
    localparam logic [2:0]       LAST_SEL = 3'(NUM_DIGITS - 1);

    scan_state_e         state_q, state_d;
    logic [2:0]          sel_q, sel_d, sel_next;
    logic [AN_WIDTH-1:0] an_q, an_d;
    logic [DW-1:0]       digit_q_q, digit_d;
    logic [DW-1:0]       pend_data_q, pend_data_d;
    logic                pend_q, pend_d;
    logic                ack_q, ack_d;
    logic                fs_q;
    logic                boundary;
    logic [NUM_DIGITS-1:0] blank_d;
    logic                zero_run;

    logic                tmr_clear, tmr_load, tmr_tc;
    logic [CNT_W-1:0]    tmr_load_val;

    display_scan_controller_scan_slot_timer #(
        .CNT_W (CNT_W)
    ) u_slot_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .tc_o       (tmr_tc)
    );

    assign sel_next = (sel_q == LAST_SEL) ? 3'd0 : sel_q + 3'd1;

    // Scan FSM next state; boundary marks entry into ON with sel=0.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        tmr_clear    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = ON_LOAD;
        boundary     = 1'b0;
        if (!scan_io.enable) begin
            state_d   = StIdle;
            sel_d     = 3'd0;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d  = StOn;
                    sel_d    = 3'd0;
                    tmr_load = 1'b1;
                    boundary = 1'b1;
                end
                StOn: begin
                    if (tmr_tc) begin
                        tmr_load = 1'b1;
                        if (DEADTIME == 0) begin
                            sel_d    = sel_next;
                            boundary = (sel_next == 3'd0);
                        end else begin
                            state_d      = StGap;
                            tmr_load_val = GAP_LOAD;
                        end
                    end
                end
                StGap: begin
                    if (tmr_tc) begin
                        state_d  = StOn;
                        sel_d    = sel_next;
                        tmr_load = 1'b1;
                        boundary = (sel_next == 3'd0);
                    end
                end
                default: begin
                    state_d   = StIdle;
                    sel_d     = 3'd0;
                    tmr_clear = 1'b1;
                end
            endcase
        end
    end

    // Shadow digits: immediate load while idle, otherwise deferred to the frame boundary.
    always_comb begin
        digit_d     = digit_q_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        ack_d       = 1'b0;
        if (state_q == StIdle && scan_io.update) begin
            // Nothing is being displayed, so there is no frame to tear; drop any stale request.
            digit_d = scan_io.digit_bus;
            ack_d   = 1'b1;
            pend_d  = 1'b0;
        end else begin
            if (boundary && pend_q) begin
                digit_d = pend_data_q;
                ack_d   = 1'b1;
                pend_d  = 1'b0;
            end
            // A newer request overrides and survives into the next frame.
            if (scan_io.update) begin
                pend_d      = 1'b1;
                pend_data_d = scan_io.digit_bus;
            end
        end
    end

    // Leading-zero mask from the next shadow value so blanking lines up with the anode register.
    always_comb begin
        blank_d  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (digit_d[i*DIGIT_W +: DIGIT_W] == '0);
            blank_d[i] = scan_io.lz_blank & zero_run;
        end
    end

    // Anode drive for the next cycle; lines at or above NUM_DIGITS are never selected.
    always_comb begin
        an_d = AN_OFF[AN_WIDTH-1:0];
        if (state_d == StOn && !blank_d[sel_d]) begin
            an_d[sel_d] = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sel_q       <= 3'd0;
            an_q        <= AN_OFF[AN_WIDTH-1:0];
            digit_q_q   <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            ack_q       <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            an_q        <= an_d;
            digit_q_q   <= digit_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            ack_q       <= ack_d;
            fs_q        <= boundary;
        end
    end

    assign scan_io.digit_q     = digit_q_q;
    assign scan_io.sel         = sel_q;
    assign scan_io.an          = an_q;
    assign scan_io.update_ack  = ack_q;
    assign scan_io.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for the scan controller: REFRESH_DIV=8 with DEADTIME=2 and DEADTIME=0 builds.
module tb_display_scan_controller;
    import display_scan_controller_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    display_scan_controller_if #(.NUM_DIGITS(6), .AN_WIDTH(8)) sif ();
    display_scan_controller_if #(.NUM_DIGITS(6), .AN_WIDTH(8)) sif0 ();

    display_scan_controller #(
        .NUM_DIGITS (6),
        .AN_WIDTH   (8),
        .REFRESH_DIV(8),
        .DEADTIME   (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .scan_io(sif)
    );

    display_scan_controller #(
        .NUM_DIGITS (6),
        .AN_WIDTH   (8),
        .REFRESH_DIV(8),
        .DEADTIME   (0)
    ) dut0 (
        .clk    (clk),
        .reset  (reset),
        .scan_io(sif0)
    );

    function automatic logic [7:0] exp_an(input int s, input bit lit);
        logic [7:0] v;
        v = 8'hFF;
        if (lit) v[s] = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        sif.enable     = 1'b0;
        sif.update     = 1'b0;
        sif.lz_blank   = 1'b0;
        sif.digit_bus  = '0;
        sif0.enable    = 1'b0;
        sif0.update    = 1'b0;
        sif0.lz_blank  = 1'b0;
        sif0.digit_bus = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (sif.sel !== 3'd0) begin
            n_fail++; $display("FAIL reset_sel: got %0d exp 0", sif.sel);
        end
        n_checks++;
        if (sif.an !== 8'hFF) begin
            n_fail++; $display("FAIL reset_an: got %h exp ff", sif.an);
        end
        n_checks++;
        if (sif.digit_q !== 24'h0) begin
            n_fail++; $display("FAIL reset_digit_q: got %h exp 000000", sif.digit_q);
        end
        n_checks++;
        if (sif.update_ack !== 1'b0 || sif.frame_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: got ack=%b fs=%b exp 0 0",
                               sif.update_ack, sif.frame_start);
        end
        n_checks++;
        if (sif0.an !== 8'hFF || sif0.sel !== 3'd0) begin
            n_fail++; $display("FAIL reset_dt0: got an=%h sel=%0d exp ff 0", sif0.an, sif0.sel);
        end
    endtask

    task automatic test_scan();
        int s, pos;
        logic [7:0] ea;
        logic efs;
        do_reset();
        sif.enable = 1'b1;
        tick();
        for (int k = 0; k < 96; k++) begin
            s   = (k / 8) % 6;
            pos = k % 8;
            ea  = exp_an(s, pos < 6);
            efs = (k % 48 == 0);
            n_checks++;
            if (sif.sel !== 3'(s) || sif.an !== ea || sif.frame_start !== efs) begin
                n_fail++;
                $display("FAIL scan k=%0d: got sel=%0d an=%h fs=%b exp sel=%0d an=%h fs=%b",
                         k, sif.sel, sif.an, sif.frame_start, s, ea, efs);
            end
            tick();
        end
    endtask

    task automatic test_update();
        logic [23:0] edq;
        logic eack;
        do_reset();
        sif.enable = 1'b1;
        tick();
        for (int k = 0; k < 146; k++) begin
            if (k < 48)       edq = 24'h000000;
            else if (k < 96)  edq = 24'h123456;
            else if (k < 144) edq = 24'h654321;
            else              edq = 24'h111111;
            eack = (k == 48 || k == 96 || k == 144);
            n_checks++;
            if (sif.digit_q !== edq || sif.update_ack !== eack ||
                sif.frame_start !== (k % 48 == 0)) begin
                n_fail++;
                $display("FAIL update k=%0d: got dq=%h ack=%b fs=%b exp dq=%h ack=%b",
                         k, sif.digit_q, sif.update_ack, sif.frame_start, edq, eack);
            end
            sif.update = (k == 10 || k == 60 || k == 62 || k == 96);
            case (k)
                10:      sif.digit_bus = 24'h123456;
                60:      sif.digit_bus = 24'hAAAAAA;
                62:      sif.digit_bus = 24'h654321;
                96:      sif.digit_bus = 24'h111111;
                default: sif.digit_bus = 24'h000000;
            endcase
            tick();
        end
        sif.update = 1'b0;
    endtask

    task automatic test_lz();
        int s, pos;
        logic [7:0] ea;
        do_reset();
        sif.digit_bus = 24'h000070;
        sif.update    = 1'b1;
        tick();
        sif.update = 1'b0;
        n_checks++;
        if (sif.digit_q !== 24'h000070 || sif.update_ack !== 1'b1) begin
            n_fail++; $display("FAIL idle_load: got dq=%h ack=%b exp 000070 1",
                               sif.digit_q, sif.update_ack);
        end
        sif.lz_blank = 1'b1;
        sif.enable   = 1'b1;
        tick();
        n_checks++;
        if (sif.update_ack !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack_pulse: got %b exp 0", sif.update_ack);
        end
        for (int k = 0; k < 48; k++) begin
            s   = (k / 8) % 6;
            pos = k % 8;
            ea  = exp_an(s, (pos < 6) && (s <= 1));
            n_checks++;
            if (sif.an !== ea || sif.sel !== 3'(s)) begin
                n_fail++; $display("FAIL lz_70 k=%0d: got an=%h sel=%0d exp an=%h sel=%0d",
                                   k, sif.an, sif.sel, ea, s);
            end
            tick();
        end
        sif.enable = 1'b0;
        tick();
        sif.digit_bus = 24'h000000;
        sif.update    = 1'b1;
        tick();
        sif.update = 1'b0;
        sif.enable = 1'b1;
        tick();
        for (int k = 0; k < 48; k++) begin
            s   = (k / 8) % 6;
            pos = k % 8;
            ea  = exp_an(s, (pos < 6) && (s == 0));
            n_checks++;
            if (sif.an !== ea) begin
                n_fail++; $display("FAIL lz_00 k=%0d: got an=%h exp an=%h", k, sif.an, ea);
            end
            tick();
        end
        sif.lz_blank = 1'b0;
    endtask

    task automatic test_disable();
        do_reset();
        sif.enable = 1'b1;
        tick();
        repeat (26) tick();
        n_checks++;
        if (sif.sel !== 3'd3 || sif.an !== 8'hF7) begin
            n_fail++; $display("FAIL dis_pre: got sel=%0d an=%h exp 3 f7", sif.sel, sif.an);
        end
        sif.enable = 1'b0;
        tick();
        n_checks++;
        if (sif.sel !== 3'd0 || sif.an !== 8'hFF) begin
            n_fail++; $display("FAIL dis_off: got sel=%0d an=%h exp 0 ff", sif.sel, sif.an);
        end
        tick();
        n_checks++;
        if (sif.an !== 8'hFF || sif.frame_start !== 1'b0) begin
            n_fail++; $display("FAIL dis_idle: got an=%h fs=%b exp ff 0", sif.an, sif.frame_start);
        end
        sif.enable = 1'b1;
        tick();
        n_checks++;
        if (sif.frame_start !== 1'b1 || sif.sel !== 3'd0 || sif.an !== 8'hFE) begin
            n_fail++; $display("FAIL dis_reen: got fs=%b sel=%0d an=%h exp 1 0 fe",
                               sif.frame_start, sif.sel, sif.an);
        end
        for (int j = 1; j < 8; j++) begin
            tick();
            n_checks++;
            if (sif.an !== ((j < 6) ? 8'hFE : 8'hFF) || sif.sel !== 3'd0) begin
                n_fail++; $display("FAIL dis_slot j=%0d: got an=%h sel=%0d", j, sif.an, sif.sel);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        do_reset();
        sif.enable = 1'b1;
        tick();
        for (int k = 0; k < 14; k++) begin
            sif.update    = (k == 10);
            sif.digit_bus = (k == 10) ? 24'h999999 : 24'h000000;
            tick();
        end
        sif.update = 1'b0;
        n_checks++;
        if (sif.an !== 8'hFF || sif.sel !== 3'd1) begin
            n_fail++; $display("FAIL rmid_gap: got an=%h sel=%0d exp ff 1", sif.an, sif.sel);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (sif.sel !== 3'd0 || sif.an !== 8'hFF || sif.digit_q !== 24'h0 ||
            sif.update_ack !== 1'b0 || sif.frame_start !== 1'b0) begin
            n_fail++; $display("FAIL rmid_rst: got sel=%0d an=%h dq=%h ack=%b fs=%b",
                               sif.sel, sif.an, sif.digit_q, sif.update_ack, sif.frame_start);
        end
        tick();
        n_checks++;
        if (sif.frame_start !== 1'b1) begin
            n_fail++; $display("FAIL rmid_restart: got fs=%b exp 1", sif.frame_start);
        end
        bad = 1'b0;
        for (int j = 0; j < 60; j++) begin
            if (sif.update_ack !== 1'b0 || sif.digit_q !== 24'h0) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL rmid_pending: got late ack/load exp none");
        end
    endtask

    task automatic test_deadtime0();
        int s;
        logic [7:0] ea;
        do_reset();
        sif0.enable = 1'b1;
        tick();
        for (int k = 0; k < 56; k++) begin
            s  = (k / 8) % 6;
            ea = exp_an(s, 1'b1);
            n_checks++;
            if (sif0.sel !== 3'(s) || sif0.an !== ea || sif0.frame_start !== (k % 48 == 0)) begin
                n_fail++; $display("FAIL dt0 k=%0d: got sel=%0d an=%h fs=%b exp sel=%0d an=%h",
                                   k, sif0.sel, sif0.an, sif0.frame_start, s, ea);
            end
            tick();
        end
        sif0.enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_update();
        test_lz();
        test_disable();
        test_reset_mid();
        test_deadtime0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
